// File: rtl/inner_product.sv
// Sequential single-precision dot product: one multiply-accumulate per cycle,
// round-to-nearest-even, denormals flushed, inf/NaN operands poisoning the result.
module inner_product #(
  parameter int N = 4
) (
  input  logic [32*N-1:0] In1,
  input  logic [32*N-1:0] In2,
  input  logic            clk,
  input  logic            rst,
  output logic [31:0]     out,
  output logic            done,
  input  logic            start
);

  localparam int DATA_W = 32;
  localparam int IW     = $clog2(N + 1);
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [32*N-1:0]     a_p0, b_p0;
  logic [DATA_W-1:0]   acc_p1;
  logic [IW-1:0]       idx;
  logic [DATA_W-1:0]   a_el, b_el;

  // RNE on a normalised 24-bit significand, then overflow to inf / underflow to signed zero
  function automatic logic [31:0] round_sat(input logic s, input logic signed [9:0] e_in,
                                            input logic [23:0] m_in, input logic g,
                                            input logic st);
    logic [24:0]       m;
    logic signed [9:0] e;
    m = {1'b0, m_in};
    e = e_in;
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {s, 31'd0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       p;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QNAN;
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) return round_sat(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    return round_sat(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [26:0]       mx, my;
    logic [53:0]       sh;
    logic [7:0]        d;
    logic [27:0]       sum;
    logic signed [9:0] e;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QNAN;
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return 32'h0;
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // Guard/round/sticky: shifted-out bits collapse into the LSB
    if (d > 8'd26) my = 27'd1;
    else begin
      sh = {my, 27'd0} >> d;
      my = {sh[53:28], sh[27] | (|sh[26:0])};
    end
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 10'sd1;
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, my};
      if (sum == 28'd0) return 32'h0;
      for (int i = 0; i < 26; i++) begin
        if (!sum[26]) begin
          sum = sum << 1;
          e   = e - 10'sd1;
        end
      end
    end
    return round_sat(x[31], e, sum[26:3], sum[2], |sum[1:0]);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (idx == IW'(N)) state_nx = DONE;
      DONE:    if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage 0: operand capture
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_p0 <= In1;
      b_p0 <= In2;
    end
  end

  always_comb begin
    a_el = '0;
    b_el = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        a_el = a_p0[DATA_W*i +: DATA_W];
        b_el = b_p0[DATA_W*i +: DATA_W];
      end
    end
  end

  // Stage 1: accumulate one element per cycle; the extra cycle at idx==N publishes the sum
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1 <= '0;
      idx    <= '0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_p1 <= '0;
            idx    <= '0;
          end
        end
        RUN: begin
          if (idx == IW'(N)) begin
            out  <= acc_p1;
            done <= 1'b1;
          end else begin
            acc_p1 <= fp_add(acc_p1, fp_mul(a_el, b_el));
            idx    <= idx + 1'b1;
          end
        end
        DONE: begin
          if (!start) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inner_product.sv
// Randomised and directed bench for inner_product against an exact-arithmetic
// float reference (exact product/sum, single rounding per operation).
module tb_inner_product;
  localparam int N = 4;

  logic [32*N-1:0] In1, In2;
  logic            clk = 1'b0;
  logic            rst, start, done;
  logic [31:0]     out;
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [31:0]     last_out = 32'h0;

  always #5 clk = ~clk;

  inner_product #(.N(N)) dut (
    .In1(In1), .In2(In2), .clk(clk), .rst(rst), .out(out), .done(done), .start(start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: value = sig * 2^lsb_exp, computed exactly then rounded once
  function automatic logic [127:0] fsig(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 128'd0;
    return {104'd0, 1'b1, x[22:0]};
  endfunction

  function automatic int fexp(input logic [31:0] x);
    return int'(x[30:23]) - 150;
  endfunction

  function automatic logic [31:0] rnd_pack(input logic s, input logic [127:0] m, input int e);
    int p, big_e, sh;
    logic [127:0] mant;
    logic g, st;
    if (m == 128'd0) return 32'h0;
    p = 0;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    big_e = p + e + 127;
    if (p > 23) begin
      sh   = p - 23;
      mant = m >> sh;
      g    = m[sh-1];
      st   = (m & ((128'd1 << (sh - 1)) - 128'd1)) != 128'd0;
    end else begin
      mant = m << (23 - p);
      g    = 1'b0;
      st   = 1'b0;
    end
    if (g && (st || mant[0])) mant = mant + 128'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      big_e++;
    end
    if (big_e >= 255) return {s, 8'hFF, 23'd0};
    if (big_e <= 0) return {s, 31'd0};
    return {s, big_e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
    return rnd_pack(a[31] ^ b[31], fsig(a) * fsig(b), fexp(a) + fexp(b));
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [127:0] ma, mb, m;
    int ea, eb, d;
    logic sa, sb, s;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
    ma = fsig(a); mb = fsig(b); ea = fexp(a); eb = fexp(b); sa = a[31]; sb = b[31];
    if (ea < eb) begin
      ma = fsig(b); mb = fsig(a); ea = fexp(b); eb = fexp(a); sa = b[31]; sb = a[31];
    end
    d = ea - eb;
    if (d > 100) begin
      if (mb != 128'd0) mb = 128'd1;
      d  = 100;
      eb = ea - 100;
    end
    ma = ma << d;
    if (sa == sb) begin
      m = ma + mb; s = sa;
    end else if (ma >= mb) begin
      m = ma - mb; s = sa;
    end else begin
      m = mb - ma; s = sb;
    end
    return rnd_pack(s, m, eb);
  endfunction

  function automatic logic [31:0] ref_dot(input logic [32*N-1:0] a, input logic [32*N-1:0] b);
    logic [31:0] acc = 32'h0;
    for (int i = 0; i < N; i++) acc = ref_add(acc, ref_mul(a[32*i +: 32], b[32*i +: 32]));
    return acc;
  endfunction

  function automatic logic [31:0] rand_fp();
    int k = int'($urandom_range(0, 15));
    logic [7:0] e;
    if (k == 0) return 32'h0;
    if (k == 1) return {1'($urandom), 8'd0, 23'($urandom)};
    if (k == 2) e = 8'($urandom_range(200, 254));
    else        e = 8'($urandom_range(110, 140));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic run_op(input logic [32*N-1:0] a, input logic [32*N-1:0] b,
                        input string tag, output logic [31:0] res);
    int cyc;
    logic [31:0] exp;
    exp = ref_dot(a, b);
    In1 = a; In2 = b; start = 1'b1;
    tick();
    cyc = 1;
    for (int i = 0; i < N; i++) begin
      In1[32*i +: 32] = $urandom;
      In2[32*i +: 32] = $urandom;
    end
    while (!done && cyc < 40) begin
      chk({tag, " out before done"}, out, last_out);
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(N + 2));
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " out"}, out, exp);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk({tag, " hold done"}, {31'd0, done}, 32'd1);
      chk({tag, " hold out"}, out, exp);
    end
    start = 1'b0;
    tick();
    chk({tag, " idle done"}, {31'd0, done}, 32'd0);
    chk({tag, " idle out"}, out, exp);
    last_out = exp;
    res = out;
  endtask

  localparam logic [32*N-1:0] BAS_A = {32'h412C0000, 32'h40BC7AE1, 32'h40CF5C29, 32'h409F5C29};
  localparam logic [32*N-1:0] BAS_B = {32'h3FAF5C29, 32'h40000000, 32'h4175AD43, 32'h40E00000};

  initial begin
    logic [31:0] r, diff;
    logic [32*N-1:0] ra, rb;
    rst = 1'b1; start = 1'b1; In1 = '0; In2 = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset out", out, 32'h0);
      chk("reset done", {31'd0, done}, 32'd0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    chk("post reset done", {31'd0, done}, 32'd0);

    run_op(BAS_A, BAS_B, "basic", r);
    diff = (r > 32'h4320DDD9) ? r - 32'h4320DDD9 : 32'h4320DDD9 - r;
    chk("basic within 4 ulp", {31'd0, diff <= 32'd4}, 32'd1);

    run_op({32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}, {N{32'h3F800000}}, "exact", r);
    chk("exact 10.0", r, 32'h41200000);

    run_op({32'h40000000, 32'hC0000000, 32'h0, 32'h0}, {32'h40400000, 32'h40400000, 32'h0, 32'h0},
           "cancel", r);
    chk("cancel +0", r, 32'h0);

    // Abort two cycles into the run
    In1 = BAS_A; In2 = BAS_B; start = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort out", out, 32'h0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("abort idle done", {31'd0, done}, 32'd0);
    chk("abort idle out", out, 32'h0);
    last_out = 32'h0;

    run_op(BAS_A, BAS_B, "restart", r);
    chk("restart value", r, ref_dot(BAS_A, BAS_B));

    run_op({32'h3F800000, 32'h7F800000, 32'h40000000, 32'h3F800000}, {N{32'h3F800000}}, "inf", r);
    chk("inf gives qnan", r, 32'h7FC00000);
    run_op({N{32'h3F800000}}, {32'h0, 32'h0, 32'h0, 32'h7F800000}, "inf last", r);
    chk("inf last gives qnan", r, 32'h7FC00000);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        ra[32*i +: 32] = rand_fp();
        rb[32*i +: 32] = rand_fp();
      end
      run_op(ra, rb, $sformatf("rand%0d", t), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
